// File: rtl/warp_inst_fetch.sv
// Instruction-fetch stage for one warp: issues instruction-memory reads and queues returns in a 3-entry buffer.
// Optional macro IF_DROP_CNT_EN adds a saturating Drop_Cnt_IF counter of dropped returns.
module warp_inst_fetch #(
  parameter int DATA = 32,
  parameter int ADDR = 12
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            GRT_RR_IF,
  input  logic [31:0]     PC_in_IF,
  input  logic            Flush_IF,
  output logic            Req_IF_IM,
  output logic [ADDR-1:0] Addr_IF_IM,
  input  logic [DATA-1:0] Inst_IM_IF,
  output logic            Valid_IF_ID,
  output logic [DATA-1:0] Inst_IF_ID,
  output logic [31:0]     PC_IF_ID,
  input  logic            Ack_ID_IF,
  output logic            valid_1_IF_PC,
  output logic            valid_2_IF_PC,
  output logic            valid_3_IF_PC,
  output logic            Drop_IF_PC,
`ifdef IF_DROP_CNT_EN
  output logic [15:0]     Drop_Cnt_IF,
`endif
  output logic [1:0]      fsmState
);

  // Decode handshake: the head entry transfers on a rising clk edge where
  // Valid_IF_ID & Ack_ID_IF; Ack_ID_IF is ignored while Valid_IF_ID is low.

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    BUSY   = 2'd1,
    SQUASH = 2'd2
  } state_t;

  state_t          state, stateNext;
  logic [1:0]      count, countNext;
  logic [DATA-1:0] instQ [3];
  logic [DATA-1:0] instNext [3];
  logic [31:0]     pcQ [3];
  logic [31:0]     pcNext [3];
  logic [31:0]     pendingPc;
  logic            issue, pop, pushReq, push, drop;
  logic [1:0]      tailIdx;

  always_comb begin
    issue     = GRT_RR_IF & ~Flush_IF;
    stateNext = issue ? BUSY : IDLE;
    if (Flush_IF && issue) stateNext = SQUASH;

    // Only a BUSY cycle carries returning data; a flush or reset discards it.
    pushReq = rst_n & (state == BUSY) & ~Flush_IF;
    pop     = Ack_ID_IF & (count != 2'd0);
    push    = pushReq & ((count != 2'd3) | pop);
    drop    = pushReq & (count == 2'd3) & ~pop;
    tailIdx = count - {1'b0, pop};

    for (int i = 0; i < 3; i++) begin
      instNext[i] = instQ[i];
      pcNext[i]   = pcQ[i];
    end
    if (pop) begin
      instNext[0] = instQ[1];
      instNext[1] = instQ[2];
      pcNext[0]   = pcQ[1];
      pcNext[1]   = pcQ[2];
    end
    for (int i = 0; i < 3; i++) begin
      if (push && tailIdx == i[1:0]) begin
        instNext[i] = Inst_IM_IF;
        pcNext[i]   = pendingPc;
      end
    end

    countNext = count - {1'b0, pop} + {1'b0, push};
    if (Flush_IF) countNext = 2'd0;
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state     <= IDLE;
      count     <= 2'd0;
      pendingPc <= 32'd0;
      for (int i = 0; i < 3; i++) begin
        instQ[i] <= '0;
        pcQ[i]   <= 32'd0;
      end
    end else begin
      state <= stateNext;
      count <= countNext;
      if (issue) pendingPc <= PC_in_IF;
      for (int i = 0; i < 3; i++) begin
        instQ[i] <= instNext[i];
        pcQ[i]   <= pcNext[i];
      end
    end
  end

`ifdef IF_DROP_CNT_EN
  logic [15:0] dropCnt;
  always_ff @(posedge clk) begin
    if (!rst_n) dropCnt <= 16'd0;
    else if (drop && dropCnt != 16'hFFFF) dropCnt <= dropCnt + 16'd1;
  end
  assign Drop_Cnt_IF = dropCnt;
`endif

  assign Req_IF_IM     = issue;
  assign Addr_IF_IM    = PC_in_IF[ADDR+1:2];
  assign Valid_IF_ID   = (count != 2'd0);
  assign Inst_IF_ID    = instQ[0];
  assign PC_IF_ID      = pcQ[0];
  assign valid_1_IF_PC = (count != 2'd0);
  assign valid_2_IF_PC = (count >= 2'd2);
  assign valid_3_IF_PC = (count == 2'd3);
  assign Drop_IF_PC    = drop;
  assign fsmState      = state;

endmodule

// File: tb/tb_warp_inst_fetch.sv
// Bench for warp_inst_fetch: queue-based fetch model checked every cycle, directed scenarios and random traffic.
module tb_warp_inst_fetch;

  logic        clk;
  logic        rst_n;
  logic        grt, flush, ack;
  logic [31:0] pcIn;
  logic [31:0] instIm;
  logic        req;
  logic [11:0] addr;
  logic        validId;
  logic [31:0] instId, pcId;
  logic        v1, v2, v3, dropPc;
  logic [1:0]  fsmState;
`ifdef IF_DROP_CNT_EN
  logic [15:0] dropCnt;
`endif

  warp_inst_fetch #(.DATA(32), .ADDR(12)) dut (
    .clk(clk), .rst_n(rst_n), .GRT_RR_IF(grt), .PC_in_IF(pcIn), .Flush_IF(flush),
    .Req_IF_IM(req), .Addr_IF_IM(addr), .Inst_IM_IF(instIm),
    .Valid_IF_ID(validId), .Inst_IF_ID(instId), .PC_IF_ID(pcId), .Ack_ID_IF(ack),
    .valid_1_IF_PC(v1), .valid_2_IF_PC(v2), .valid_3_IF_PC(v3), .Drop_IF_PC(dropPc),
`ifdef IF_DROP_CNT_EN
    .Drop_Cnt_IF(dropCnt),
`endif
    .fsmState(fsmState)
  );

  // clock
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // model state: buffered {inst, pc} entries, the read in flight, drop tally
  logic [63:0] exp_q[$];
  logic        inflight;
  logic [31:0] inflightPc;
  int          mDrops;
  int          tests;
  int          fails;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s actual=%0h expected=%0h at %0t", name, act, exp, $time);
    end
  endtask

  // driver: apply one cycle of inputs, settle before the check point
  task automatic drive(input logic g, input logic [31:0] p, input logic f, input logic a, input logic r);
    grt    = g;
    pcIn   = p;
    flush  = f;
    ack    = a;
    rst_n  = r;
    instIm = $urandom;
    #3;
  endtask

  // compare the DUT to the model, then advance both across one clock edge
  task automatic tick();
    int sz;
    sz = exp_q.size();
    chk("req", req, grt & ~flush);
    chk("addr", addr, pcIn[13:2]);
    chk("valid", validId, sz > 0);
    chk("v1", v1, sz >= 1);
    chk("v2", v2, sz >= 2);
    chk("v3", v3, sz == 3);
    chk("drop", dropPc, rst_n & inflight & ~flush & (sz == 3) & ~ack);
    if (sz > 0) begin
      chk("head_inst", instId, exp_q[0][63:32]);
      chk("head_pc", pcId, exp_q[0][31:0]);
    end
`ifdef IF_DROP_CNT_EN
    chk("drop_cnt", dropCnt, mDrops);
`endif
    @(posedge clk);
    if (!rst_n) begin
      exp_q.delete();
      inflight = 1'b0;
      mDrops   = 0;
    end else if (flush) begin
      exp_q.delete();
      inflight = 1'b0;
    end else begin
      if (ack && exp_q.size() > 0) void'(exp_q.pop_front());
      if (inflight) begin
        if (exp_q.size() < 3) exp_q.push_back({instIm, inflightPc});
        else if (mDrops < 65535) mDrops++;
      end
      inflight   = grt;
      inflightPc = pcIn;
    end
    #1;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) begin
      drive(0, 0, 0, 0, 1);
      tick();
    end
  endtask

  initial begin
    tests = 0; fails = 0; mDrops = 0;
    inflight = 1'b0; inflightPc = 0;
    #1;

    // reset
    for (int i = 0; i < 2; i++) begin
      drive(0, 0, 0, 0, 0);
      tick();
    end
    chk("rst_valid", validId, 0);
    chk("rst_v1", v1, 0);
    chk("rst_state", fsmState, 0);

    // single fetch latency
    drive(1, 32'h100, 0, 0, 1);
    chk("lit_req", req, 1);
    chk("lit_addr", addr, 12'h040);
    tick();
    drive(0, 0, 0, 0, 1);
    tick();
    chk("lit_valid", validId, 1);
    chk("lit_pc", pcId, 32'h100);
    chk("lit_v1", v1, 1);
    chk("lit_v2", v2, 0);

    // fill to three, then a drop
    drive(0, 0, 1, 0, 1); tick();
    drive(1, 32'h0, 0, 0, 1); tick();
    drive(1, 32'h4, 0, 0, 1); tick();
    drive(1, 32'h8, 0, 0, 1); tick();
    drive(0, 0, 0, 0, 1); tick();
    chk("full_v3", {v1, v2, v3}, 3'b111);
    drive(1, 32'hC, 0, 0, 1); tick();
    drive(0, 0, 0, 0, 1);
    chk("lit_drop", dropPc, 1);
    tick();
    drive(0, 0, 0, 0, 1);
    chk("drop_once", dropPc, 0);
    chk("drop_v3", v3, 1);
    chk("drop_head", pcId, 32'h0);
    tick();

    // full buffer, return coincides with ack
    drive(1, 32'hC, 0, 0, 1); tick();
    drive(0, 0, 0, 1, 1);
    chk("pp_nodrop", dropPc, 0);
    tick();
    chk("pp_head", pcId, 32'h4);
    chk("pp_v3", v3, 1);
    drive(0, 0, 0, 1, 1); tick();
    drive(0, 0, 0, 1, 1); tick();
    chk("pp_tail", pcId, 32'hC);

    // flush on the return cycle
    drive(0, 0, 1, 0, 1); tick();
    drive(1, 32'h20, 0, 0, 1); tick();
    drive(1, 32'h40, 1, 0, 1);
    chk("fl_req", req, 0);
    tick();
    chk("fl_v1", v1, 0);
    chk("fl_valid", validId, 0);
    drive(1, 32'h80, 0, 0, 1); tick();
    drive(0, 0, 0, 0, 1); tick();
    chk("fl_pc", pcId, 32'h80);
    chk("fl_v2", v2, 0);
    idle(2);

    // reset while busy with two entries buffered
    drive(0, 0, 1, 0, 1); tick();
    drive(1, 32'h200, 0, 0, 1); tick();
    drive(1, 32'h204, 0, 0, 1); tick();
    drive(1, 32'h208, 0, 0, 1); tick();
    chk("rb_v2", v2, 1);
    drive(0, 0, 0, 0, 0); tick();
    chk("rb_out", {validId, instId, pcId, v1, v2, v3, dropPc}, 0);
    chk("rb_state", fsmState, 0);
    drive(0, 0, 0, 0, 1); tick();
    chk("rb_stale", validId, 0);

    // five drops, survive a flush, cleared by reset
    for (int i = 0; i < 3; i++) begin
      drive(1, 32'h300 + 4 * i, 0, 0, 1); tick();
    end
    for (int i = 0; i < 5; i++) begin
      drive(1, 32'h400 + 4 * i, 0, 0, 1); tick();
    end
    drive(0, 0, 0, 0, 1); tick();
    chk("five_drops", mDrops, 5);
`ifdef IF_DROP_CNT_EN
    chk("lit_cnt5", dropCnt, 16'd5);
    drive(0, 0, 1, 0, 1); tick();
    chk("lit_cnt_flush", dropCnt, 16'd5);
    drive(0, 0, 0, 0, 0); tick();
    chk("lit_cnt_rst", dropCnt, 16'd0);
`endif
    drive(0, 0, 1, 0, 1); tick();

    // random traffic
    for (int i = 0; i < 3000; i++) begin
      drive($urandom_range(0, 9) < 7, $urandom, $urandom_range(0, 19) == 0,
            $urandom_range(0, 1), $urandom_range(0, 99) != 0);
      tick();
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/warp_inst_fetch.md
Name: warp_inst_fetch

Overview:
- Instruction-fetch stage for one warp; the consumer end of the PC-update interface.
- Takes the PC_out driven by PC update, issues a word read to the instruction memory, and queues returned instructions in a 3-entry in-order buffer for decode.
- Reports buffer occupancy back to PC update as valid_1/2/3.
- Squashes in-flight and buffered work on any PC redirect.

Parameters:
- DATA, 32, instruction word width.
- ADDR, 12, instruction memory word-address width.

Ports:
- clk  input  1  clock.
- rst_n  input  1  reset, synchronous, active-low.
- GRT_RR_IF  input  1  fetch grant for this warp this cycle.
- PC_in_IF  input  32  PC to fetch (PC update output).
- Flush_IF  input  1  redirect (TM start, ALU/SIMT/ID branch); squash all.
- Req_IF_IM  output  1  instruction memory read enable.
- Addr_IF_IM  output  ADDR  word address = PC_in_IF[ADDR+1:2].
- Inst_IM_IF  input  DATA  read data, valid exactly 1 cycle after Req_IF_IM.
- Valid_IF_ID  output  1  buffer head valid.
- Inst_IF_ID  output  DATA  head instruction.
- PC_IF_ID  output  32  head PC.
- Ack_ID_IF  input  1  decode consumes head; ignored when Valid_IF_ID=0.
- valid_1_IF_PC, valid_2_IF_PC, valid_3_IF_PC  output  1 each  occupancy >=1, >=2, ==3.
- Drop_IF_PC  output  1  one-cycle pulse: returned instruction discarded because the buffer was full.

Behaviour:
- Reset (rst_n=0 at clk edge): FSM=IDLE; count=0; all outputs 0; pending PC cleared; in-flight data ignored. Reset has priority over all inputs, including mid-fetch.
- FSM states:
  - IDLE: no read in flight.
  - BUSY: read issued last cycle; data returns this cycle.
  - SQUASH: read in flight but flushed; returned data discarded.
- Issue:
  - Req_IF_IM = GRT_RR_IF & ~Flush_IF, combinational, allowed in any state. Back-to-back fetch gives 1 instruction/cycle.
  - On issue, latch PC_in_IF into the pending PC.
  - Next state: BUSY if issued, else IDLE; overridden by the flush rule.
- Return (state BUSY): push {Inst_IM_IF, pending PC} at the tail, unless Flush_IF is high this cycle.
- Flush_IF=1:
  - count <= 0; the returning instruction, if any, is not pushed.
  - No request is issued this cycle.
  - A BUSY state goes to IDLE. SQUASH is only entered if a request issued in the same cycle as the flush, which cannot happen by the rule above; the state is kept for robustness and exits to IDLE next cycle with no push.
- Buffer:
  - FIFO, depth 3; slot 0 is the head; outputs are registered from slot 0.
  - Pop when Ack_ID_IF & Valid_IF_ID; entries shift toward the head.
  - Push and pop in the same cycle: count unchanged; the new entry lands behind the remaining entries.
  - Full (count==3) with push and pop together: the push is accepted.
  - Full with push and no pop: the instruction is dropped and Drop_IF_PC pulses for that cycle. PC update rewinds by 4 on stall, so the dropped PC is refetched.
  - Empty with pop: ignored.
- Occupancy flags are registered from count, so they reflect state after the current edge.
- Latency: grant at cycle N → Valid_IF_ID at N+2 when the buffer was empty.
- PC_in_IF[1:0] are ignored; the full 32-bit PC is carried to PC_IF_ID unmodified.

Optional Feature:
- Macro IF_DROP_CNT_EN.
- When defined: adds output Drop_Cnt_IF [15:0]. It increments on every Drop_IF_PC pulse, saturates at 16'hFFFF, clears on reset only (not on flush).
- When undefined: port and counter are absent; all other behaviour is identical.

Test Plan:
- Reset then grant with PC_in_IF=0x100 → Req_IF_IM=1, Addr_IF_IM=0x040; two cycles later Valid_IF_ID=1, PC_IF_ID=0x100, valid_1=1, valid_2=0.
- Grant 3 consecutive cycles (PCs 0x0, 0x4, 0x8), Ack_ID_IF=0 → valid_1/2/3 all 1; fourth grant at 0xC → Drop_IF_PC pulses once, count stays 3, head PC 0x0.
- Buffer full, returning fetch and Ack_ID_IF in the same cycle → no drop; head advances to 0x4; tail holds the new PC 0xC.
- Grant at 0x20, Flush_IF on the return cycle → no push, count=0, valid_1=0, Req_IF_IM=0 that cycle; a following grant at 0x80 delivers PC 0x80 only.
- Deassert rst_n while BUSY with 2 entries buffered → next cycle all outputs 0, state IDLE; stale Inst_IM_IF is never pushed.
- IF_DROP_CNT_EN defined: force 5 drops → Drop_Cnt_IF=5; a flush leaves it at 5; reset clears it to 0.
